// File: rtl/alu_ac_unit_if.sv
// Strobe/data bundle between control_unit and the accumulator/ALU stage.
// The master drives operands and strobes; the slave returns AC, the register
// read port, the combinational ALU result and the registered flags.
interface alu_ac_unit_if;
  logic [15:0] bus_in;
  logic        b_from_bus;
  logic [3:0]  alu_sel;
  logic [3:0]  reg_sel;
  logic [3:0]  reg_write_sel;
  logic        reg_we;
  logic        AC_Load;
  logic        AC_Inc;
  logic        FLAGS_Load;
  logic [15:0] ac_out;
  logic [15:0] reg_out;
  logic [15:0] alu_out;
  logic [3:0]  FLAGS_Value;

  modport master (
    output bus_in, b_from_bus, alu_sel, reg_sel, reg_write_sel,
           reg_we, AC_Load, AC_Inc, FLAGS_Load,
    input  ac_out, reg_out, alu_out, FLAGS_Value
  );

  modport slave (
    input  bus_in, b_from_bus, alu_sel, reg_sel, reg_write_sel,
           reg_we, AC_Load, AC_Inc, FLAGS_Load,
    output ac_out, reg_out, alu_out, FLAGS_Value
  );
endinterface

// File: rtl/alu_ac_unit.sv
// Execution stage: accumulator, 16x16 register file, 4-bit FLAGS and a
// purely combinational ALU whose operand A is always the pre-edge AC.
// FLAGS layout: [3]=Z, [2]=C, [1]=N, [0]=V.
module alu_ac_unit (
  input  logic         clk,
  input  logic         rst,
  alu_ac_unit_if.slave bus
);

  logic [15:0] ac_reg;
  logic [3:0]  flags_reg;
  logic [15:0] rf_reg [16];

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [16:0] wide;
  logic [15:0] result;
  logic        carry;
  logic        ovf;
  logic [3:0]  flags_next;

  assign op_a = ac_reg;
  assign op_b = bus.b_from_bus ? bus.bus_in : rf_reg[bus.reg_sel];

  // ALU: 17-bit arithmetic, carry/overflow only meaningful for add/sub/shift
  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (bus.alu_sel)
      4'h0: begin
        wide   = {1'b0, op_a} + {1'b0, op_b};
        result = wide[15:0];
        carry  = wide[16];
        ovf    = (op_a[15] == op_b[15]) && (result[15] != op_a[15]);
      end
      4'h1: begin
        wide   = {1'b0, op_a} - {1'b0, op_b};
        result = wide[15:0];
        // Carry means "no borrow", i.e. A >= B unsigned.
        carry  = ~wide[16];
        ovf    = (op_a[15] != op_b[15]) && (result[15] != op_a[15]);
      end
      4'h2: result = op_a & op_b;
      4'h3: result = op_a | op_b;
      4'h4: result = op_a ^ op_b;
      4'h5: result = ~op_a;
      4'h6: begin
        result = {op_a[14:0], 1'b0};
        carry  = op_a[15];
      end
      4'h7: begin
        result = {1'b0, op_a[15:1]};
        carry  = op_a[0];
      end
      4'h8: result = op_b;
      default: result = op_a;
    endcase
  end

  assign flags_next = {(result == 16'h0000), carry, result[15], ovf};

  // Accumulator and flags: reset, then load, then increment, then hold
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_reg    <= '0;
      flags_reg <= '0;
    end else begin
      if (bus.AC_Load) begin
        ac_reg <= result;
      end else if (bus.AC_Inc) begin
        ac_reg <= ac_reg + 16'h0001;
      end
      if (bus.FLAGS_Load) begin
        flags_reg <= flags_next;
      end
    end
  end

  // Register file write; reads see the old contents until the next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (bus.reg_we) begin
      rf_reg[bus.reg_write_sel] <= result;
    end
  end

  assign bus.ac_out      = ac_reg;
  assign bus.reg_out     = rf_reg[bus.reg_sel];
  assign bus.alu_out     = result;
  assign bus.FLAGS_Value = flags_reg;

endmodule
